// File: rtl/mux_scan_pkg.sv
// Shared mode codes and FSM encoding for the scanning N:1 mux.
package mux_scan_pkg;

  localparam logic [1:0] MODE_MAN  = 2'd0;
  localparam logic [1:0] MODE_SCAN = 2'd1;
  localparam logic [1:0] MODE_HOLD = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/mux_next_en.sv
// Round-robin finder: first enabled channel strictly above cur, wrapping.
// With cur = CH-1 the result is the lowest enabled channel.
module mux_next_en
  import mux_scan_pkg::*;
#(
  parameter int CH    = 4,
  parameter int SEL_W = 2
) (
  input  logic [CH-1:0]    ch_en,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] next,
  output logic             wrap,
  output logic             none
);

  logic             found;
  logic [SEL_W-1:0] idx;

  // Offset CH lands back on cur itself, so a lone enabled channel finds itself.
  always_comb begin
    next  = cur;
    found = 1'b0;
    idx   = '0;
    for (int off = 1; off <= CH; off++) begin
      idx = SEL_W'((int'(cur) + off) % CH);
      if (!found && ch_en[idx]) begin
        next  = idx;
        found = 1'b1;
      end
    end
  end

  assign none = ~|ch_en;
  assign wrap = found && (next <= cur);

endmodule

// File: rtl/mux_nto1_scan.sv
// N:1 registered mux with manual select, round-robin auto-scan with dwell,
// and freeze. busy is a direct decode of the FSM state.
module mux_nto1_scan
  import mux_scan_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CH      = 4,
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      sel_in,
  input  logic [CH-1:0]         ch_en,
  input  logic [DWELL_W-1:0]    dwell,
  input  logic                  start,
  input  logic [CH*WIDTH-1:0]   din,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  output logic [SEL_W-1:0]      cur_sel,
  output logic                  busy,
  output logic                  scan_wrap
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CH - 1);
  localparam logic [SEL_W:0]   CH_L    = (SEL_W + 1)'(CH);

  state_t               state, state_d;
  logic [DWELL_W-1:0]   dwell_cnt, cnt_d;
  logic [WIDTH-1:0]     dout_d;
  logic                 valid_d;
  logic [SEL_W-1:0]     sel_d;
  logic                 wrap_d;

  logic [WIDTH-1:0]     ch_data [CH];
  logic [WIDTH-1:0]     man_dout;
  logic                 man_valid;
  logic [SEL_W-1:0]     find_cur;
  logic [SEL_W-1:0]     find_next;
  logic                 find_wrap;
  logic                 find_none;

  always_comb begin
    for (int k = 0; k < CH; k++) begin
      ch_data[k] = din[k*WIDTH +: WIDTH];
    end
  end

  // Out-of-range manual selects produce a zero, invalid output.
  always_comb begin
    man_valid = ({1'b0, sel_in} < CH_L);
    man_dout  = man_valid ? ch_data[sel_in] : '0;
  end

  // One finder serves both searches: lowest-enabled from IDLE, next-enabled in SCAN.
  assign find_cur = (state == ST_IDLE) ? LAST_CH : cur_sel;

  mux_next_en #(
    .CH    (CH),
    .SEL_W (SEL_W)
  ) u_next_en (
    .ch_en (ch_en),
    .cur   (find_cur),
    .next  (find_next),
    .wrap  (find_wrap),
    .none  (find_none)
  );

  always_comb begin
    state_d = state;
    cnt_d   = dwell_cnt;
    dout_d  = dout;
    valid_d = dout_valid;
    sel_d   = cur_sel;
    wrap_d  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mode == MODE_MAN) begin
          sel_d   = sel_in;
          dout_d  = man_dout;
          valid_d = man_valid;
        end else if (mode == MODE_SCAN && start) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
          sel_d   = find_none ? cur_sel : find_next;
        end
      end
      ST_SCAN: begin
        if (mode == MODE_MAN) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          sel_d   = sel_in;
          dout_d  = man_dout;
          valid_d = man_valid;
        end else if (mode == MODE_SCAN) begin
          if (find_none) begin
            valid_d = 1'b0;
            cnt_d   = '0;
          end else begin
            dout_d  = ch_data[cur_sel];
            valid_d = ch_en[cur_sel];
            // >= covers dwell being lowered below the running count.
            if (!ch_en[cur_sel] || dwell_cnt >= dwell) begin
              sel_d  = find_next;
              cnt_d  = '0;
              wrap_d = find_wrap;
            end else begin
              cnt_d = dwell_cnt + DWELL_W'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      dwell_cnt  <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      cur_sel    <= '0;
      scan_wrap  <= 1'b0;
    end else begin
      state      <= state_d;
      dwell_cnt  <= cnt_d;
      dout       <= dout_d;
      dout_valid <= valid_d;
      cur_sel    <= sel_d;
      scan_wrap  <= wrap_d;
    end
  end

  assign busy = (state == ST_SCAN);

endmodule
